mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_pkg.sv | 33 +++
 rtl/mem_array.sv | 31 +++
 rtl/mem_responder.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_pkg;

    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 8;
    localparam int DEPTH     = 1 << ADDR_W;
    localparam int BURST_LEN = 4;

    // Command encoding as it appears on the mode pins.
    typedef enum logic [1:0] {
        MODE_RD    = 2'b00,
        MODE_WR    = 2'b01,
        MODE_BURST = 2'b10,
        MODE_NOP   = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        GRANT      = 3'd1,
        WAIT_START = 3'd2,
        ACCESS     = 3'd3,
        RESP       = 3'd4
    } state_e;

    // Address of a given burst beat; wraps naturally at the top of the array.
    function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] base,
                                                     input logic [1:0]        beat);
        return base + ADDR_W'(beat);
    endfunction

endpackage

// File: rtl/mem_array.sv
// 256x8 storage with synchronous write, combinational read, synchronous clear.
// Latency: write lands on the clock edge; read data follows raddr combinationally.
// Backpressure: none; a write is accepted on every cycle we_i is high.
module mem_array
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              clr_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Clear wins over write so a reset cycle always leaves the array all-zero.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_responder.sv
// Single-initiator memory responder: req/gnt handshake, start-strobed command, timed response.
// Latency: gnt one cycle after req; first rdy exactly LATENCY cycles after start.
// Backpressure: none; req/start outside their accepting states are dropped, not queued.
module mem_responder
    import mem_pkg::*;
#(
    parameter int LATENCY       = 2,
    parameter int START_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] data_in,
    output logic              gnt,
    output logic              rdy,
    output logic [DATA_W-1:0] data_out,
    output logic              data_oe
);

    // Counter reload values; LATENCY-1 because the cycle that accepts start counts as one.
    localparam logic [2:0] LAT_INIT  = 3'(LATENCY - 1);
    localparam logic [7:0] TO_LAST   = 8'(START_TIMEOUT - 1);
    localparam logic [1:0] BEAT_LAST = 2'(BURST_LEN - 1);

    state_e            state_q;
    mode_e             mode_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [2:0]        lat_cnt_q;
    logic [7:0]        to_cnt_q;
    logic [1:0]        beat_q;
    logic              gnt_q;
    logic              rdy_q;
    logic              data_oe_q;
    logic [DATA_W-1:0] data_out_q;

    logic              mem_we;
    logic [ADDR_W-1:0] rd_addr_d;
    logic [DATA_W-1:0] rd_data;
    logic              access_done;

    assign access_done = (state_q == ACCESS) && (lat_cnt_q == 3'd0);

    // The write commits on the same edge that moves the FSM into RESP.
    assign mem_we = access_done && (mode_q == MODE_WR);

    // While in RESP, look one beat ahead so the next burst word is ready at the edge.
    always_comb begin
        rd_addr_d = addr_q;
        if (state_q == RESP) begin
            rd_addr_d = beat_addr(addr_q, beat_q + 2'd1);
        end
    end

    mem_array u_mem (
        .clk     (clk),
        .clr_n   (rst_n),
        .we_i    (mem_we),
        .waddr_i (addr_q),
        .wdata_i (wdata_q),
        .raddr_i (rd_addr_d),
        .rdata_o (rd_data)
    );

    // Control FSM with its counters, capture registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mode_q     <= MODE_RD;
            addr_q     <= '0;
            wdata_q    <= '0;
            lat_cnt_q  <= '0;
            to_cnt_q   <= '0;
            beat_q     <= '0;
            gnt_q      <= 1'b0;
            rdy_q      <= 1'b0;
            data_oe_q  <= 1'b0;
            data_out_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        state_q <= GRANT;
                        gnt_q   <= 1'b1;
                    end
                end
                GRANT: begin
                    state_q  <= WAIT_START;
                    gnt_q    <= 1'b0;
                    to_cnt_q <= '0;
                end
                WAIT_START: begin
                    // A start on the last allowed cycle still wins over the timeout.
                    if (start) begin
                        addr_q    <= addr;
                        mode_q    <= mode_e'(mode);
                        wdata_q   <= data_in;
                        lat_cnt_q <= LAT_INIT;
                        state_q   <= ACCESS;
                    end else if (to_cnt_q == TO_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 8'd1;
                    end
                end
                ACCESS: begin
                    if (lat_cnt_q == 3'd0) begin
                        state_q <= RESP;
                        rdy_q   <= 1'b1;
                        beat_q  <= '0;
                        if (mode_q == MODE_RD || mode_q == MODE_BURST) begin
                            data_oe_q  <= 1'b1;
                            data_out_q <= rd_data;
                        end else begin
                            data_oe_q  <= 1'b0;
                            data_out_q <= '0;
                        end
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 3'd1;
                    end
                end
                RESP: begin
                    if (mode_q == MODE_BURST && beat_q != BEAT_LAST) begin
                        beat_q     <= beat_q + 2'd1;
                        data_out_q <= rd_data;
                    end else begin
                        state_q    <= IDLE;
                        rdy_q      <= 1'b0;
                        data_oe_q  <= 1'b0;
                        data_out_q <= '0;
                        beat_q     <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt      = gnt_q;
    assign rdy      = rdy_q;
    assign data_oe  = data_oe_q;
    assign data_out = data_out_q;

endmodule
